// File: rtl/ceespu_pkg.sv
// Shared ceespu definitions: PC width, default interrupt vector and PC-control FSM encoding.
package ceespu_pkg;

  localparam int unsigned PC_W        = 14;
  localparam int unsigned FLUSH_CNT_W = 3;

  localparam logic [PC_W-1:0] IRQ_VECTOR_DEFAULT = 14'h0010;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_IRQ   = 2'd2
  } pc_state_e;

endpackage

// File: rtl/ceespu_pc_ctrl.sv
// PC sequencer: arbitrates branch/reti/interrupt/stall requests and kills fetch bubbles after redirects.
// Optional interrupt support is built when CEESPU_IRQ_EN is defined.
module ceespu_pc_ctrl
  import ceespu_pkg::*;
#(
  parameter int unsigned     FLUSH_CYCLES = 2,
  parameter logic [PC_W-1:0] IRQ_VECTOR   = IRQ_VECTOR_DEFAULT
) (
  input  logic            I_clk,
  input  logic            I_rst_n,
  input  logic            I_hazard,
  input  logic            I_mem_busy,
  input  logic            I_branch_taken,
  input  logic [PC_W-1:0] I_branch_target,
  input  logic            I_reti,
  input  logic            I_irq,
  input  logic [PC_W-1:0] I_pc,
  output logic            O_stall,
  output logic            O_branch,
  output logic [PC_W-1:0] O_branchAddress,
  output logic            O_flush,
  output logic            O_irq_ack,
  output logic [PC_W-1:0] O_epc
);

  localparam logic [FLUSH_CNT_W-1:0] FLUSH_LOAD = FLUSH_CNT_W'(FLUSH_CYCLES);

  pc_state_e              state_q, state_d;
  logic [FLUSH_CNT_W-1:0] cnt_q, cnt_d;

`ifdef CEESPU_IRQ_EN
  logic            ie_q, ie_d;
  logic [PC_W-1:0] epc_q, epc_d;

  assign O_epc = epc_q;
`else
  wire unused_irq_inputs = ^{I_irq, I_reti, I_pc, IRQ_VECTOR};

  assign O_epc = '0;
`endif

  // State, flush counter and interrupt context registers
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
`ifdef CEESPU_IRQ_EN
      ie_q    <= 1'b1;
      epc_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
`ifdef CEESPU_IRQ_EN
      ie_q    <= ie_d;
      epc_q   <= epc_d;
`endif
    end
  end

  // Next-state and PC action selection; priority branch > reti > interrupt > stall
  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    O_stall         = 1'b0;
    O_branch        = 1'b0;
    O_branchAddress = '0;
    O_flush         = 1'b0;
    O_irq_ack       = 1'b0;
`ifdef CEESPU_IRQ_EN
    ie_d            = ie_q;
    epc_d           = epc_q;
`endif

    case (state_q)
      ST_RUN: begin
        if (I_branch_taken) begin
          O_branch        = 1'b1;
          O_branchAddress = I_branch_target;
          state_d         = ST_FLUSH;
          cnt_d           = FLUSH_LOAD;
        end
`ifdef CEESPU_IRQ_EN
        else if (I_reti) begin
          O_branch        = 1'b1;
          O_branchAddress = epc_q;
          ie_d            = 1'b1;
          state_d         = ST_FLUSH;
          cnt_d           = FLUSH_LOAD;
        end else if (I_irq && ie_q && !I_hazard && !I_mem_busy) begin
          // Capture the return point now; the redirect happens from ST_IRQ.
          epc_d   = I_pc;
          ie_d    = 1'b0;
          state_d = ST_IRQ;
        end
`endif
        else begin
          O_stall = I_hazard | I_mem_busy;
        end
      end

      ST_FLUSH: begin
        O_flush = 1'b1;
        O_stall = I_hazard | I_mem_busy;
        // Killed instructions cannot redirect, and a busy memory holds the window open.
        if (!I_mem_busy) begin
          if (cnt_q <= FLUSH_CNT_W'(1)) begin
            state_d = ST_RUN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - FLUSH_CNT_W'(1);
          end
        end
      end

`ifdef CEESPU_IRQ_EN
      ST_IRQ: begin
        O_branch        = 1'b1;
        O_branchAddress = IRQ_VECTOR;
        O_irq_ack       = 1'b1;
        O_flush         = 1'b1;
        state_d         = ST_FLUSH;
        cnt_d           = FLUSH_LOAD;
      end
`endif

      default: begin
        state_d = ST_RUN;
        cnt_d   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_ceespu_pc_ctrl.sv
// Directed self-checking bench for ceespu_pc_ctrl; exercises the interrupt path only when CEESPU_IRQ_EN is defined.
module tb_ceespu_pc_ctrl;
  import ceespu_pkg::*;

  logic            I_clk = 1'b0;
  logic            I_rst_n = 1'b0;
  logic            I_hazard = 1'b0;
  logic            I_mem_busy = 1'b0;
  logic            I_branch_taken = 1'b0;
  logic [PC_W-1:0] I_branch_target = '0;
  logic            I_reti = 1'b0;
  logic            I_irq = 1'b0;
  logic [PC_W-1:0] I_pc = '0;
  logic            O_stall;
  logic            O_branch;
  logic [PC_W-1:0] O_branchAddress;
  logic            O_flush;
  logic            O_irq_ack;
  logic [PC_W-1:0] O_epc;

  int checks = 0;
  int errors = 0;

  ceespu_pc_ctrl #(
    .FLUSH_CYCLES(2),
    .IRQ_VECTOR  (14'h0010)
  ) dut (
    .I_clk          (I_clk),
    .I_rst_n        (I_rst_n),
    .I_hazard       (I_hazard),
    .I_mem_busy     (I_mem_busy),
    .I_branch_taken (I_branch_taken),
    .I_branch_target(I_branch_target),
    .I_reti         (I_reti),
    .I_irq          (I_irq),
    .I_pc           (I_pc),
    .O_stall        (O_stall),
    .O_branch       (O_branch),
    .O_branchAddress(O_branchAddress),
    .O_flush        (O_flush),
    .O_irq_ack      (O_irq_ack),
    .O_epc          (O_epc)
  );

  always #5 I_clk = ~I_clk;

  logic [31:0] obs;
  assign obs = {14'd0, O_stall, O_branch, O_flush, O_irq_ack, O_branchAddress};

  function automatic logic [31:0] outs(input logic s, input logic b, input logic f,
                                       input logic a, input logic [PC_W-1:0] addr);
    return {14'd0, s, b, f, a, addr};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Apply one cycle of inputs at the falling edge and let the combinational outputs settle.
  task automatic drive(input logic h, input logic mb, input logic bt, input logic [PC_W-1:0] tgt,
                       input logic reti, input logic irq, input logic [PC_W-1:0] pc);
    @(negedge I_clk);
    I_hazard        = h;
    I_mem_busy      = mb;
    I_branch_taken  = bt;
    I_branch_target = tgt;
    I_reti          = reti;
    I_irq           = irq;
    I_pc            = pc;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout obs=0x%08h exp=finish", obs);
    $fatal(1, "timeout");
  end

  initial begin
    #2;
    check("rst_outs", obs, outs(0, 0, 0, 0, 14'h0));
    check("rst_epc", 32'(O_epc), 32'h0);
    @(negedge I_clk);
    I_rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      drive(0, 0, 0, 14'h0, 0, 0, 14'h0);
      check("idle", obs, outs(0, 0, 0, 0, 14'h0));
    end

    drive(1, 0, 0, 14'h0, 0, 0, 14'h0);
    check("run_hazard", obs, outs(1, 0, 0, 0, 14'h0));
    drive(0, 1, 0, 14'h0, 0, 0, 14'h0);
    check("run_busy", obs, outs(1, 0, 0, 0, 14'h0));

    // Branch wins over a simultaneous memory stall, then two flush cycles
    drive(0, 1, 1, 14'h0123, 0, 0, 14'h0);
    check("br_redirect", obs, outs(0, 1, 0, 0, 14'h0123));
    drive(0, 0, 0, 14'h0, 0, 0, 14'h0);
    check("br_flush1", obs, outs(0, 0, 1, 0, 14'h0));
    drive(0, 0, 0, 14'h0, 0, 0, 14'h0);
    check("br_flush2", obs, outs(0, 0, 1, 0, 14'h0));
    drive(0, 0, 0, 14'h0, 0, 0, 14'h0);
    check("br_done", obs, outs(0, 0, 0, 0, 14'h0));

    // Hazard inside the flush window stalls but does not freeze the counter
    drive(0, 0, 1, 14'h0200, 0, 0, 14'h0);
    check("fh_redirect", obs, outs(0, 1, 0, 0, 14'h0200));
    drive(1, 0, 0, 14'h0, 0, 0, 14'h0);
    check("fh_hazard", obs, outs(1, 0, 1, 0, 14'h0));
    drive(0, 0, 0, 14'h0, 0, 0, 14'h0);
    check("fh_flush2", obs, outs(0, 0, 1, 0, 14'h0));
    drive(0, 0, 0, 14'h0, 0, 0, 14'h0);
    check("fh_done", obs, outs(0, 0, 0, 0, 14'h0));

    // Memory busy freezes the window for three cycles; a branch inside is ignored
    drive(0, 0, 1, 14'h0300, 0, 0, 14'h0);
    check("fb_redirect", obs, outs(0, 1, 0, 0, 14'h0300));
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, (i == 1), 14'h03FF, 0, 0, 14'h0);
      check("fb_busy", obs, outs(1, 0, 1, 0, 14'h0));
    end
    drive(0, 0, 0, 14'h0, 0, 0, 14'h0);
    check("fb_flush4", obs, outs(0, 0, 1, 0, 14'h0));
    drive(0, 0, 0, 14'h0, 0, 0, 14'h0);
    check("fb_flush5", obs, outs(0, 0, 1, 0, 14'h0));
    drive(0, 0, 0, 14'h0, 0, 0, 14'h0);
    check("fb_done", obs, outs(0, 0, 0, 0, 14'h0));

    // Reset in the middle of a flush window aborts it at once
    drive(0, 0, 1, 14'h0050, 0, 0, 14'h0);
    check("rf_redirect", obs, outs(0, 1, 0, 0, 14'h0050));
    drive(0, 0, 0, 14'h0, 0, 0, 14'h0);
    check("rf_flush1", obs, outs(0, 0, 1, 0, 14'h0));
    I_rst_n = 1'b0;
    #1;
    check("rf_reset", obs, outs(0, 0, 0, 0, 14'h0));
    @(negedge I_clk);
    I_rst_n = 1'b1;
    drive(0, 0, 0, 14'h0, 0, 0, 14'h0);
    check("rf_release", obs, outs(0, 0, 0, 0, 14'h0));

`ifdef CEESPU_IRQ_EN
    // Branch outranks a pending interrupt; the interrupt waits out the flush window
    drive(0, 0, 1, 14'h0077, 0, 1, 14'h003F);
    check("irq_vs_br", obs, outs(0, 1, 0, 0, 14'h0077));
    drive(0, 0, 0, 14'h0, 0, 1, 14'h0040);
    check("irq_in_fl1", obs, outs(0, 0, 1, 0, 14'h0));
    drive(0, 0, 0, 14'h0, 0, 1, 14'h0040);
    check("irq_in_fl2", obs, outs(0, 0, 1, 0, 14'h0));
    drive(0, 0, 0, 14'h0, 0, 1, 14'h0040);
    check("irq_take", obs, outs(0, 0, 0, 0, 14'h0));
    drive(0, 0, 0, 14'h0, 0, 1, 14'h0041);
    check("irq_entry", obs, outs(0, 1, 1, 1, 14'h0010));
    check("irq_epc", 32'(O_epc), 32'h0040);
    drive(0, 0, 0, 14'h0, 0, 1, 14'h0010);
    check("irq_fl1", obs, outs(0, 0, 1, 0, 14'h0));
    drive(0, 0, 0, 14'h0, 0, 1, 14'h0011);
    check("irq_fl2", obs, outs(0, 0, 1, 0, 14'h0));
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 14'h0, 0, 1, 14'h0012);
      check("irq_masked", obs, outs(0, 0, 0, 0, 14'h0));
    end
    drive(0, 0, 0, 14'h0, 1, 1, 14'h0055);
    check("reti", obs, outs(0, 1, 0, 0, 14'h0040));
    drive(0, 0, 0, 14'h0, 0, 1, 14'h0040);
    check("reti_fl1", obs, outs(0, 0, 1, 0, 14'h0));
    drive(0, 0, 0, 14'h0, 0, 1, 14'h0041);
    check("reti_fl2", obs, outs(0, 0, 1, 0, 14'h0));
    drive(0, 0, 0, 14'h0, 0, 1, 14'h0041);
    check("irq_retake", obs, outs(0, 0, 0, 0, 14'h0));
    drive(0, 0, 0, 14'h0, 0, 0, 14'h0042);
    check("irq_entry2", obs, outs(0, 1, 1, 1, 14'h0010));
    check("irq_epc2", 32'(O_epc), 32'h0041);
    drive(0, 0, 0, 14'h0, 0, 0, 14'h0);
    check("irq2_fl1", obs, outs(0, 0, 1, 0, 14'h0));
    I_rst_n = 1'b0;
    #1;
    check("irq_rst_outs", obs, outs(0, 0, 0, 0, 14'h0));
    check("irq_rst_epc", 32'(O_epc), 32'h0);
    @(negedge I_clk);
    I_rst_n = 1'b1;
`else
    // Interrupt and return requests have no effect in this build
    for (int i = 0; i < 20; i++) begin
      drive(0, 0, 0, 14'h0, (i % 5 == 0), 1, 14'h0040);
      check("noirq_outs", obs, outs(0, 0, 0, 0, 14'h0));
      check("noirq_epc", 32'(O_epc), 32'h0);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ceespu_pc_ctrl.md
# ceespu_pc_ctrl

Sequencer that drives the stall and branch controls of the ceespu program counter. It takes branch, interrupt-return, hazard and memory-busy requests from the pipeline and picks one PC action per cycle. It adds a fixed-length flush window after every redirect and, optionally, a single-level interrupt entry/return mechanism. It sits between the decode/execute stages and the PC register block, and drives its `I_stall`, `I_branch` and `I_branchAddress` inputs directly.

## Interface
- `FLUSH_CYCLES`, 2 — fetch-bubble cycles killed after any redirect (1..7).
- `IRQ_VECTOR`, 14'h0010 — interrupt handler entry address.
- `I_clk` in 1 — clock, rising-edge.
- `I_rst_n` in 1 — asynchronous, active-low reset.
- `I_hazard` in 1 — decode load-use hazard; hold fetch.
- `I_mem_busy` in 1 — instruction/data memory not ready; hold fetch.
- `I_branch_taken` in 1 — execute-stage taken branch/jump, one-cycle pulse.
- `I_branch_target` in 14 — target for `I_branch_taken`.
- `I_reti` in 1 — return-from-interrupt executed, one-cycle pulse.
- `I_irq` in 1 — level-sensitive external interrupt request.
- `I_pc` in 14 — current fetch address from the PC block.
- `O_stall` out 1 — to PC block stall input.
- `O_branch` out 1 — to PC block branch input.
- `O_branchAddress` out 14 — to PC block branch address.
- `O_flush` out 1 — kill the instruction currently in fetch/decode.
- `O_irq_ack` out 1 — one-cycle pulse on interrupt entry.
- `O_epc` out 14 — saved return address.

## Operation
- State machine states: RUN, FLUSH, IRQ.
- Registers: state, 3-bit flush counter, IE bit, EPC.
- Request priority each cycle is `I_branch_taken` > `I_reti` > interrupt > stall.
- In RUN with `I_branch_taken`:
  - `O_branch`=1 and `O_branchAddress`=`I_branch_target`, combinationally in the same cycle.
  - Next state is FLUSH with counter=`FLUSH_CYCLES`.
- In RUN with `I_reti` (no branch):
  - `O_branch`=1 and `O_branchAddress`=EPC.
  - IE<=1; next state is FLUSH.
- Interrupt in RUN, taken when `I_irq` && IE && no branch/reti && !`I_hazard` && !`I_mem_busy`:
  - EPC<=`I_pc`, IE<=0, next state is IRQ.
  - No PC action in the taking cycle.
- In IRQ (exactly one cycle):
  - `O_branch`=1, `O_branchAddress`=`IRQ_VECTOR`, `O_irq_ack`=1, `O_flush`=1.
  - Next state is FLUSH.
- In FLUSH:
  - `O_flush`=1 and the counter decrements each cycle; when the counter reaches 1, next state is RUN.
  - `I_branch_taken` and `I_reti` are ignored: killed instructions cannot redirect.
  - `I_hazard` and `I_mem_busy` still raise `O_stall`; the counter freezes while `I_mem_busy`=1.
- `O_stall` = (`I_hazard` | `I_mem_busy`) in RUN and FLUSH, forced 0 whenever `O_branch`=1.
- When no branch is driven, `O_branchAddress` = 0.
- `I_branch_taken` together with `I_mem_busy` in RUN: the branch wins. The PC block already gives branch priority over stall.
- `I_irq` while IE=0: held pending (level); taken after `I_reti` sets IE and FLUSH completes.
- Address arithmetic is 14-bit unsigned; no wrap checks are needed.

## Timing
- Reset (async assert, sync deassert handled upstream):
  - state=RUN, counter=0, IE=1, EPC=0.
  - All outputs 0.
- Branch/reti redirect: zero-cycle latency (combinational from input to `O_branch`); the PC block loads on the next edge.
- Interrupt: 1 cycle from acceptance to `O_branch` (IRQ state), then `FLUSH_CYCLES` flush cycles.
- `O_irq_ack` is high for exactly one cycle per interrupt entry.
- Reset asserted mid-FLUSH or mid-IRQ aborts immediately to reset values; a pending EPC is lost.

## Configuration
- `CEESPU_IRQ_EN` defined: interrupt logic, IE, EPC, IRQ state and `I_reti` handling are present.
- `CEESPU_IRQ_EN` undefined:
  - `I_irq` and `I_reti` are ignored.
  - `O_irq_ack`=0 and `O_epc`=0 constant.
  - The IRQ state is not built.
  - Port list is unchanged.

## Structure
- Shared package `ceespu_pkg`:
  - state enum (RUN/FLUSH/IRQ) encoding.
  - `PC_W`=14.
  - default `IRQ_VECTOR`.
- No sub-module; the flush counter and FSM live in one always-block pair (registered state, combinational outputs).

## Test plan
- Reset release, no requests: all outputs 0 for 10 cycles.
- `I_branch_taken`=1, target 14'h0123 in RUN: same cycle `O_branch`=1, addr 0x0123, `O_stall`=0; then `O_flush`=1 for exactly 2 cycles.
- `I_irq`=1 with `I_pc`=0x0040:
  - next cycle `O_branch`=1, addr 0x0010, `O_irq_ack`=1.
  - `O_epc`=0x0040.
  - later `I_reti` gives `O_branch`=1, addr 0x0040.
- `I_irq` held during handler (IE=0): no second ack until after `I_reti` and its 2 flush cycles.
- `I_mem_busy`=1 for 3 cycles inside FLUSH: `O_stall`=1 and the flush window extends by 3 cycles; a branch pulse inside FLUSH produces no `O_branch`.
- Without `CEESPU_IRQ_EN`: `I_irq`=1 for 20 cycles gives `O_irq_ack`=0 and no `O_branch`.
